// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit adder sequencer driving an external 1-bit full adder
//
// Purpose:
//   Latches operands on an accepted start, then feeds the external full adder
//   one bit per clock, LSB first. The carry is fed back from fa_co and the sum
//   bits are collected in a right-shifting result register.
//
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag on ovf).
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start, a, b, cin   request and operands (sampled only in IDLE or DONE)
//   fa_x, fa_y, fa_ci  to the full adder: current A bit, B bit and running carry
//   fa_s, fa_co        from the full adder: sum bit and carry out
//   busy, done         state decodes: RUN and DONE
//   sum, cout, ovf     registered result, held until the next accepted start

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic in_run;
  logic accept;
  logic last_bit;

  assign in_run   = (state == S_RUN);
  // start is only honoured when no job is in flight; DONE may chain directly.
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = in_run && (cnt == CW'(WIDTH - 1));

  assign busy  = in_run;
  assign done  = (state == S_DONE);

  // Adder inputs are gated so the shared cell sees a quiet 0 outside a run.
  assign fa_x  = in_run & areg[0];
  assign fa_y  = in_run & breg[0];
  assign fa_ci = in_run & carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state <= S_RUN;
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            state <= S_DONE;
            cout  <= fa_co;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the MSB, carry holds the carry into the MSB and fa_co the carry out;
  // their XOR is the two's-complement overflow condition.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= carry ^ fa_co;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_x, fa_y, fa_ci;
  logic             fa_s, fa_co;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int compared = 0;
  int mismatched = 0;

`ifdef SERIAL_ADD_OVF_EN
  localparam logic T1_OVF = 1'b1;
`else
  localparam logic T1_OVF = 1'b0;
`endif

  // Reference 1-bit full adder cell.
  assign fa_s  = fa_x ^ fa_y ^ fa_ci;
  assign fa_co = (fa_x & fa_y) | (fa_x & fa_ci) | (fa_y & fa_ci);

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .fa_x  (fa_x),
    .fa_y  (fa_y),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues a start at the next edge and leaves the bench in RUN cycle 1.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    a = av;
    b = bv;
    cin = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_fa", {fa_x, fa_y, fa_ci}, 3'b000);

    // T1 basic: 0x5A + 0x33 = 0x8D; per-cycle adder drive and busy window
    issue(8'h5A, 8'h33, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      logic [7:0] av;
      logic [7:0] bv;
      av = 8'h5A;
      bv = 8'h33;
      chk("t1_busy", busy, 1'b1);
      chk("t1_done_early", done, 1'b0);
      chk("t1_fa_x", fa_x, av[i]);
      chk("t1_fa_y", fa_y, bv[i]);
      tick();
    end
    chk("t1_done", done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_sum", sum, 8'h8D);
    chk("t1_cout", cout, 1'b0);
    chk("t1_ovf", ovf, T1_OVF);
    chk("t1_fa_idle", {fa_x, fa_y, fa_ci}, 3'b000);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_sum_held", sum, 8'h8D);

    // T2 carry ripple
    issue(8'hFF, 8'h01, 1'b0);
    repeat (WIDTH) tick();
    chk("t2a_done", done, 1'b1);
    chk("t2a_sum", sum, 8'h00);
    chk("t2a_cout", cout, 1'b1);
    chk("t2a_ovf", ovf, 1'b0);
    tick();
    issue(8'hFF, 8'h00, 1'b1);
    chk("t2b_fa_ci", fa_ci, 1'b1);
    repeat (WIDTH) tick();
    chk("t2b_done", done, 1'b1);
    chk("t2b_sum", sum, 8'h00);
    chk("t2b_cout", cout, 1'b1);
    chk("t2b_ovf", ovf, 1'b0);
    tick();

    // T3 start while busy is ignored
    issue(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_busy", busy, 1'b1);
    repeat (WIDTH - 3) tick();
    chk("t3_done", done, 1'b1);
    chk("t3_sum", sum, 8'h30);
    chk("t3_cout", cout, 1'b0);
    tick();
    chk("t3_idle", {busy, done}, 2'b00);

    // T4 back-to-back with start held through DONE
    a = 8'h01;
    b = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    tick();
    repeat (WIDTH) tick();
    chk("t4_done1", done, 1'b1);
    chk("t4_sum1", sum, 8'h02);
    tick();
    start = 1'b0;
    chk("t4_busy2", busy, 1'b1);
    chk("t4_done_off", done, 1'b0);
    chk("t4_sum_cleared", sum, 8'h00);
    repeat (WIDTH) tick();
    chk("t4_done2", done, 1'b1);
    chk("t4_sum2", sum, 8'h02);
    tick();

    // T5 reset mid-run
    issue(8'hFF, 8'hFF, 1'b1);
    tick();
    tick();
    tick();
    chk("t5_busy_pre", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_sum", sum, 8'h00);
    chk("t5_cout", cout, 1'b0);
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_fa", {fa_x, fa_y, fa_ci}, 3'b000);
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("t5_no_done", {busy, done}, 2'b00);
      tick();
    end

    // T6 reset wins over start
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("t6_busy", busy, 1'b0);
    tick();
    chk("t6_idle", {busy, done}, 2'b00);
    chk("t6_sum", sum, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
